// File: rtl/prog_loader.sv
// prog_loader: byte-serial program-memory loader.
// Assembles little-endian 32-bit words from host bytes and writes them from
// address 0. Each session starts with a length byte and ends with an XOR
// checksum byte. The core is held in reset while a load is running and after
// any load that failed.
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [7:0]        byte_in,
  input  logic              byte_stb,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  // Largest legal length byte: the full memory depth.
  localparam logic [31:0]     CAPACITY = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic            s1_q, s2_q, s3_q;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     word_q, word_d;
  logic [7:0]      chk_q, chk_d;
  logic            hold_q, hold_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            stb_edge;
  logic [31:0]     len_ext;
  logic            len_ok;

  // byte_stb comes from an asynchronous pin: two flops for metastability,
  // a third to find the rising edge. byte_in itself is held stable by the
  // host long enough to be sampled directly on the edge cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= byte_stb;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign stb_edge = s2_q & ~s3_q;
  assign len_ext  = {24'd0, byte_in};
  assign len_ok   = (byte_in != 8'd0) && (len_ext <= CAPACITY);

  // State register and session datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: every register here is cleared by rst, including the word and
    // address registers, so mem_addr/mem_wdata are never X after reset.
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      chk_q   <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      chk_q   <= chk_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update for the load session.
  always_comb begin
    // NOTE: every variable gets its hold value first; any path that leaves
    // one unassigned would otherwise infer a latch.
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    word_d  = word_q;
    chk_d   = chk_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          state_d = S_LEN;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          chk_d   = '0;
          hold_d  = 1'b1;
        end
      end

      S_LEN: begin
        if (!load_req) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          hold_d  = 1'b1;
        end else if (stb_edge) begin
          if (len_ok) begin
            state_d = S_DATA;
            len_d   = len_ext[ADDR_W:0];
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end

      S_DATA: begin
        if (!load_req) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          hold_d  = 1'b1;
        end else if (stb_edge) begin
          word_d[8*idx_q +: 8] = byte_in;
          chk_d                = chk_q ^ byte_in;
          idx_d                = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        // The write in this cycle always completes, even on abort.
        cnt_d = cnt_q + CNT_ONE;
        if (!load_req) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          hold_d  = 1'b1;
        end else if (cnt_d == len_q) begin
          state_d = S_CHK;
        end else begin
          state_d = S_DATA;
        end
      end

      S_CHK: begin
        if (!load_req) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          hold_d  = 1'b1;
        end else if (stb_edge) begin
          if (byte_in == chk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end

      S_DONE, S_ERR: begin
        // A new session needs load_req to fall and rise again.
        if (!load_req) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign mem_we        = (state_q == S_WRITE);
  assign mem_addr      = cnt_q[ADDR_W-1:0];
  assign mem_wdata     = word_q;
  assign cpu_hold      = hold_q;
  assign busy          = (state_q == S_LEN) || (state_q == S_DATA) ||
                         (state_q == S_WRITE) || (state_q == S_CHK);
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader.
// Table-driven sessions, hand-written corner sequences and randomized
// sessions compared against a word/checksum model of the load protocol.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic [7:0]  byte_in;
  logic        byte_stb;

  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold, busy, done, err;
  logic [8:0]  words_written;

  logic        s_mem_we;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic        s_cpu_hold, s_busy, s_done, s_err;
  logic [2:0]  s_words_written;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .byte_in(byte_in),
    .byte_stb(byte_stb), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .err(err), .words_written(words_written)
  );

  // Small-memory instance for the length-limit case.
  prog_loader #(.ADDR_W(2)) dut_s (
    .clk(clk), .rst(rst), .load_req(load_req), .byte_in(byte_in),
    .byte_stb(byte_stb), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .cpu_hold(s_cpu_hold), .busy(s_busy),
    .done(s_done), .err(s_err), .words_written(s_words_written)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  len;
    int          nd;
    logic [63:0] dbytes;   // byte i at [8i+7:8i]
    logic [7:0]  ck;
    int          exp_n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        exp_done;
    logic        exp_err;
    logic        exp_hold;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  wr_t        wr_q[$];
  wr_t        exp_q[$];
  logic [7:0] stream[$];
  int         we_run = 0;
  int         we_max = 0;
  int         s_we_cnt = 0;
  vec_t       vt[3];

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_q.push_back('{32'(mem_addr), mem_wdata});
      we_run = we_run + 1;
      if (we_run > we_max) we_max = we_run;
    end else begin
      we_run = 0;
    end
    if (s_mem_we) s_we_cnt = s_we_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Host byte transfer: data set up first, strobe high for hi clocks, low 3.
  task automatic send_byte(input logic [7:0] b, input int hi);
    byte_in = b;
    tick();
    byte_stb = 1'b1;
    ticks(hi);
    byte_stb = 1'b0;
    ticks(3);
  endtask

  task automatic play();
    foreach (stream[i]) send_byte(stream[i], 3);
  endtask

  task automatic start_session(input string tag);
    wr_q.delete();
    exp_q.delete();
    load_req = 1'b1;
    tick();
    tick();
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_hold_start"}, cpu_hold, 1);
  endtask

  task automatic cmp_writes(input string tag);
    check({tag, "_nwrites"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_waddr"}, wr_q[i].addr, exp_q[i].addr);
      check({tag, "_wdata"}, wr_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic run_vec(input int k, input string tag);
    start_session(tag);
    stream.delete();
    stream.push_back(vt[k].len);
    for (int i = 0; i < vt[k].nd; i++) stream.push_back(vt[k].dbytes[8*i +: 8]);
    if (vt[k].nd > 0) stream.push_back(vt[k].ck);
    if (vt[k].exp_n > 0) exp_q.push_back('{32'd0, vt[k].w0});
    if (vt[k].exp_n > 1) exp_q.push_back('{32'd1, vt[k].w1});
    play();
    ticks(2);
    check({tag, "_done"}, done, vt[k].exp_done);
    check({tag, "_err"}, err, vt[k].exp_err);
    check({tag, "_hold"}, cpu_hold, vt[k].exp_hold);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_words"}, words_written, vt[k].exp_n);
    cmp_writes(tag);
    load_req = 1'b0;
    ticks(2);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_hold"}, cpu_hold, vt[k].exp_hold);
    check({tag, "_idle_done"}, done, vt[k].exp_done);
  endtask

  initial begin
    rst = 1'b1;
    load_req = 1'b0;
    byte_in = 8'h00;
    byte_stb = 1'b0;

    vt[0] = '{8'h02, 8, 64'h00000013_00100093, 8'h90, 2, 32'h00100093, 32'h00000013, 1'b1, 1'b0, 1'b0};
    vt[1] = '{8'h02, 8, 64'h00000013_00100093, 8'h00, 2, 32'h00100093, 32'h00000013, 1'b0, 1'b1, 1'b1};
    vt[2] = '{8'h00, 0, 64'h0, 8'h00, 0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};

    ticks(2);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_words", words_written, 0);
    rst = 1'b0;
    tick();

    // Table: good load, bad checksum, zero length.
    for (int k = 0; k < 3; k++) run_vec(k, $sformatf("vec%0d", k));

    // Length above the capacity of a 4-word memory.
    s_we_cnt = 0;
    start_session("len5");
    stream.delete();
    stream.push_back(8'h05);
    play();
    ticks(2);
    check("len5_small_err", s_err, 1);
    check("len5_small_busy", s_busy, 0);
    check("len5_small_we", s_we_cnt, 0);
    check("len5_wide_busy", busy, 1);
    load_req = 1'b0;
    ticks(2);

    // Abort after five data bytes.
    start_session("abort");
    stream.delete();
    stream = '{8'h02, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13};
    play();
    check("abort_err_before", err, 0);
    load_req = 1'b0;
    tick();
    check("abort_err", err, 1);
    check("abort_busy", busy, 0);
    check("abort_hold", cpu_hold, 1);
    send_byte(8'h00, 3);
    send_byte(8'h00, 3);
    send_byte(8'h00, 3);
    exp_q.push_back('{32'd0, 32'h00100093});
    cmp_writes("abort");
    check("abort_words", words_written, 1);

    // Reset in the middle of the data phase.
    start_session("rstmid");
    stream.delete();
    stream = '{8'h02, 8'h93, 8'h00};
    play();
    rst = 1'b1;
    load_req = 1'b0;
    tick();
    check("rstmid_we", mem_we, 0);
    check("rstmid_addr", mem_addr, 0);
    check("rstmid_wdata", mem_wdata, 0);
    check("rstmid_hold", cpu_hold, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_err", err, 0);
    check("rstmid_words", words_written, 0);
    rst = 1'b0;
    tick();
    run_vec(0, "after_rst");

    // Strobe timing: one word, 4th-byte strobe held high for 10 clocks.
    start_session("timing");
    send_byte(8'h01, 3);
    send_byte(8'h93, 3);
    send_byte(8'h00, 3);
    send_byte(8'h10, 3);
    byte_in = 8'h00;
    tick();
    byte_stb = 1'b1;
    tick();                                  // edge k: first high sample
    check("t_we_k", mem_we, 0);
    tick();                                  // edge k+1
    check("t_we_k1", mem_we, 0);
    tick();                                  // edge k+2: byte consumed
    check("t_we_k2", mem_we, 1);
    check("t_addr_k2", mem_addr, 0);
    check("t_wdata_k2", mem_wdata, 32'h00100093);
    tick();                                  // edge k+3
    check("t_we_k3", mem_we, 0);
    ticks(6);
    byte_stb = 1'b0;
    ticks(3);
    check("t_words_long", words_written, 1);
    check("t_nwr_long", wr_q.size(), 1);
    check("t_busy_chk", busy, 1);
    send_byte(8'h83, 3);
    ticks(2);
    check("t_done", done, 1);
    send_byte(8'h55, 3);                     // ignored in DONE
    check("t_done_ign_done", done, 1);
    check("t_done_ign_busy", busy, 0);
    check("t_done_ign_err", err, 0);
    check("t_done_ign_words", words_written, 1);
    load_req = 1'b0;
    ticks(2);
    send_byte(8'hAA, 3);                     // ignored in IDLE
    check("t_idle_busy", busy, 0);
    check("t_idle_done", done, 1);
    check("t_idle_nwr", wr_q.size(), 1);

    // Randomized sessions against the protocol model.
    for (int r = 0; r < 8; r++) begin
      int          n;
      logic [7:0]  x;
      logic [7:0]  d[$];
      logic [7:0]  ck;
      logic        good;
      n = 1 + int'($urandom_range(0, 3));
      x = 8'h00;
      d.delete();
      for (int i = 0; i < 4 * n; i++) begin
        d.push_back(8'($urandom_range(0, 255)));
        x = x ^ d[i];
      end
      good = ($urandom_range(0, 2) != 0);
      ck = good ? x : (x ^ 8'(1 + $urandom_range(0, 254)));
      start_session($sformatf("rnd%0d", r));
      for (int w = 0; w < n; w++)
        exp_q.push_back('{32'(w), {d[4*w+3], d[4*w+2], d[4*w+1], d[4*w]}});
      stream.delete();
      stream.push_back(8'(n));
      foreach (d[i]) stream.push_back(d[i]);
      stream.push_back(ck);
      play();
      ticks(2);
      check($sformatf("rnd%0d_done", r), done, good);
      check($sformatf("rnd%0d_err", r), err, !good);
      check($sformatf("rnd%0d_hold", r), cpu_hold, !good);
      check($sformatf("rnd%0d_words", r), words_written, n);
      cmp_writes($sformatf("rnd%0d", r));
      load_req = 1'b0;
      ticks(2);
      check($sformatf("rnd%0d_idle_hold", r), cpu_hold, !good);
    end

    check("we_pulse_width", we_max, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-serial writer that fills the instruction program memory before the pipelined RISC-V core runs.
- Receives bytes from the top-level input pins, assembles them into 32-bit instruction words and writes those words sequentially from address 0.
- Verifies a trailing XOR checksum.
- Holds the core in reset (`cpu_hold`) while loading, and after any failed load.

Parameters:
- ADDR_W, 8, program-memory word-address width; capacity is 2**ADDR_W words.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- load_req, input, 1, level; high starts and sustains a load session.
- byte_in, input, 8, data byte from host pins.
- byte_stb, input, 1, asynchronous strobe from host pin; its rising edge marks byte_in valid.
- mem_we, output, 1, program-memory write enable; one-cycle pulse per word.
- mem_addr, output, ADDR_W, word address for the write.
- mem_wdata, output, 32, assembled instruction word.
- cpu_hold, output, 1, keeps the core in reset when high.
- busy, output, 1, session in progress.
- done, output, 1, sticky flag: last session succeeded.
- err, output, 1, sticky flag: last session failed.
- words_written, output, ADDR_W+1, number of words written in the current or last session.

Behaviour:
- Reset: state IDLE; all outputs 0, including cpu_hold; internal byte index, word count, checksum and synchronizer flops are cleared.
- Strobe synchronizer:
  - byte_stb passes through 2 flops (s1, s2), plus s3 for edge detect; edge = s2 & ~s3.
  - byte_stb sampled high at edge k ⇒ byte_in consumed at edge k+2.
  - Host holds byte_in stable from before the strobe rise until 4 clocks after it.
  - Host holds strobe high ≥3 clocks and low ≥3 clocks, so edges are ≥6 clocks apart.
- States: IDLE, LEN, DATA, WRITE, CHK, DONE, ERR.
  - IDLE: load_req=1 ⇒ LEN next cycle. On that transition, clear done, err, words_written and checksum; set cpu_hold=1 and busy=1. Strobe edges in IDLE, DONE and ERR are ignored.
  - LEN: on edge, N=byte_in.
    - N==0 or N>2**ADDR_W ⇒ ERR.
    - Otherwise ⇒ DATA, with byte index 0 and word count 0.
  - DATA: on edge, byte k (k=0..3) goes to word bits [8k+7:8k] (little-endian); chk ^= byte_in. After byte 3 ⇒ WRITE.
  - WRITE: exactly one cycle.
    - mem_we=1, mem_addr=word count, mem_wdata=assembled word.
    - words_written increments at the end of the cycle.
    - If this was word N-1 ⇒ CHK; else ⇒ DATA.
    - mem_we is 1 only in WRITE.
    - For the 4th-byte strobe sampled at edge k, the write cycle spans edges k+2 to k+3.
  - CHK: on edge.
    - byte_in==chk ⇒ DONE: done=1, cpu_hold=0, busy=0.
    - Otherwise ⇒ ERR: err=1, cpu_hold stays 1, busy=0.
  - DONE: load_req=0 ⇒ IDLE; done stays 1.
  - ERR: load_req=0 ⇒ IDLE; err and cpu_hold stay 1 until the next session succeeds or rst.
  - DONE or ERR with load_req still 1: stay; no new session starts until load_req drops and rises again.
- Abort: load_req=0 in LEN, DATA, WRITE or CHK ⇒ IDLE next cycle with err=1, cpu_hold=1, busy=0.
  - A WRITE cycle already in progress still writes.
  - No further writes occur.
- Reset mid-session: synchronous; the write in that cycle is suppressed (mem_we=0 once rst is sampled); memory contents are left as they are.
- mem_addr and mem_wdata are don't-care when mem_we=0 but must not be X after reset (they are driven from reset-cleared registers).
- words_written saturates naturally at N ≤ 2**ADDR_W; there is no wrap.

Test Plan:
1. Good load: load_req=1; bytes 02, 93 00 10 00, 13 00 00 00, 90 ⇒ writes (0, 0x00100093) and (1, 0x00000013). Then done=1, err=0, cpu_hold=0, words_written=2, exactly 2 mem_we pulses.
2. Bad checksum: same stream with final byte 00 ⇒ the same 2 writes occur. Then err=1, done=0, cpu_hold=1; after load_req drops, state is IDLE and cpu_hold stays 1.
3. Length errors: N=00 ⇒ err=1, no mem_we. With ADDR_W=2, N=05 ⇒ err=1, no mem_we.
4. Abort: N=02, 5 data bytes, then load_req=0 ⇒ a single write (0, word0); err=1 the next cycle; no further writes even if strobes continue.
5. Reset mid-DATA: rst after 2 data bytes ⇒ the next cycle shows all outputs 0. A fresh session identical to test 1 then succeeds with writes at addr 0 and 1.
6. Timing and ignore rules:
   - Strobe pulses in IDLE or DONE ⇒ no state change.
   - Strobe held high 10 clocks ⇒ one byte consumed.
   - Byte consumed exactly 2 edges after the first high sample.
   - mem_we pulse is 1 cycle wide.
